// File: rtl/hash_func_pipe_param.sv
// rtl/hash_func_pipe_param.sv - pipelined multiply-by-33/XOR byte hash, BYTES_PER_STAGE bytes per stage
module hash_func_pipe_param #(
    parameter int          DATA_BYTES      = 52,
    parameter int          BYTES_PER_STAGE = 4,
    parameter int          KEY_W           = 16,
    parameter logic [31:0] SEED            = 32'h0000_1505,
    parameter int          TAG_W           = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [8*DATA_BYTES-1:0] i_data,
    input  logic [31:0]             i_length,
    input  logic [TAG_W-1:0]        i_tag,
    input  logic                    i_start,
    input  logic                    i_stall_pipe,
    output logic [KEY_W-1:0]        hash_key,
    output logic [TAG_W-1:0]        o_tag,
    output logic                    o_err,
    output logic                    o_valid,
    output logic                    o_empty
);

    localparam int          NUM_STAGES = DATA_BYTES / BYTES_PER_STAGE;
    localparam int          DW         = 8 * DATA_BYTES;
    localparam int          LEN_W      = $clog2(DATA_BYTES + 1);
    localparam logic [31:0] MAX_LEN    = 32'(DATA_BYTES);
    localparam logic [KEY_W-1:0] SEED_K = SEED[KEY_W-1:0];

    // Stage s register holds the request as it enters stage s; the fold of
    // that stage's bytes is combinational on the way to the next register.
    logic [NUM_STAGES-1:0] v;
    logic [KEY_W-1:0]      h_q    [NUM_STAGES];
    logic [DW-1:0]         data_q [NUM_STAGES];
    logic [LEN_W-1:0]      len_q  [NUM_STAGES];
    logic [TAG_W-1:0]      tag_q  [NUM_STAGES];
    logic                  err_q  [NUM_STAGES];
    logic [KEY_W-1:0]      h_fold [NUM_STAGES];

    logic                  len_err;
    logic [LEN_W-1:0]      len_clamp;

    // Over-long keys are flagged and hashed over the full key field only.
    assign len_err   = (i_length > MAX_LEN);
    assign len_clamp = len_err ? LEN_W'(DATA_BYTES) : i_length[LEN_W-1:0];

    // Folds the bytes owned by one stage; bytes past the length leave h alone.
    function automatic logic [KEY_W-1:0] fold_stage(
        input logic [KEY_W-1:0] h_in,
        input logic [DW-1:0]    data,
        input logic [LEN_W-1:0] len,
        input int               stage
    );
        logic [KEY_W-1:0] h;
        logic [7:0]       b;
        int               idx;
        h = h_in;
        for (int j = 0; j < BYTES_PER_STAGE; j++) begin
            idx = stage * BYTES_PER_STAGE + j;
            b   = data[DW-1-8*idx -: 8];
            if (idx < int'(len)) begin
                h = ((h << 5) + h) ^ KEY_W'(b);
            end
        end
        return h;
    endfunction

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_fold
        assign h_fold[g] = fold_stage(h_q[g], data_q[g], len_q[g], g);
    end

    // Valid bits shift one stage per unstalled edge and clear at once on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v <= '0;
        end else if (!i_stall_pipe) begin
            v[0] <= i_start;
            for (int s = 1; s < NUM_STAGES; s++) begin
                v[s] <= v[s-1];
            end
        end
    end

    // Payload registers need no reset: they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (!i_stall_pipe) begin
            h_q[0]    <= SEED_K;
            data_q[0] <= i_data;
            len_q[0]  <= len_clamp;
            tag_q[0]  <= i_tag;
            err_q[0]  <= len_err;
            for (int s = 1; s < NUM_STAGES; s++) begin
                h_q[s]    <= h_fold[s-1];
                data_q[s] <= data_q[s-1];
                len_q[s]  <= len_q[s-1];
                tag_q[s]  <= tag_q[s-1];
                err_q[s]  <= err_q[s-1];
            end
        end
    end

    // Result register after the last fold; holds its payload when idle or stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_valid  <= 1'b0;
            hash_key <= '0;
            o_tag    <= '0;
            o_err    <= 1'b0;
        end else if (!i_stall_pipe) begin
            o_valid <= v[NUM_STAGES-1];
            if (v[NUM_STAGES-1]) begin
                hash_key <= h_fold[NUM_STAGES-1];
                o_tag    <= tag_q[NUM_STAGES-1];
                o_err    <= err_q[NUM_STAGES-1];
            end
        end
    end

    assign o_empty = ~(|v) & ~o_valid;

endmodule

// File: tb/tb_hash_func_pipe_param.sv
// tb/tb_hash_func_pipe_param.sv - directed vector bench for hash_func_pipe_param
module tb_hash_func_pipe_param;

    localparam int DB = 52;
    localparam int DW = 8 * DB;
    localparam int KW = 16;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] i_data;
    logic [31:0]   i_length;
    logic [TW-1:0] i_tag;
    logic          i_start;
    logic          i_stall_pipe;
    logic [KW-1:0] hash_key;
    logic [TW-1:0] o_tag;
    logic          o_err;
    logic          o_valid;
    logic          o_empty;

    hash_func_pipe_param dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_data       (i_data),
        .i_length     (i_length),
        .i_tag        (i_tag),
        .i_start      (i_start),
        .i_stall_pipe (i_stall_pipe),
        .hash_key     (hash_key),
        .o_tag        (o_tag),
        .o_err        (o_err),
        .o_valid      (o_valid),
        .o_empty      (o_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [31:0]   len;
        logic [TW-1:0] tag;
        logic [KW-1:0] hash;
        logic          err;
    } vec_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [KW-1:0] hash;
        logic          err;
        int            acc;
    } exp_t;

    vec_t          tbl [12];
    vec_t          idle;
    exp_t          expq [$];
    int            checks = 0;
    int            errors = 0;
    int            ucount = 0;
    logic [KW-1:0] last_hash = '0;

    function automatic logic [KW-1:0] ref_hash(input logic [DW-1:0] d, input logic [31:0] len);
        logic [KW-1:0] h;
        int            n;
        n = (len > 32'd52) ? 52 : int'(len);
        h = 16'h1505;
        for (int i = 0; i < n; i++) begin
            h = (h * 16'd33) ^ {8'h00, d[DW-1-8*i -: 8]};
        end
        return h;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One clock: drive at the falling edge, then score what the outputs show
    // against the inputs that will be seen at the coming rising edge.
    task automatic cycle(input logic start, input vec_t v, input logic stall);
        exp_t e;
        @(negedge clk);
        i_start      = start;
        i_data       = v.data;
        i_length     = v.len;
        i_tag        = v.tag;
        i_stall_pipe = stall;
        if (!stall) ucount++;
        if (o_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got tag %0h expected none", o_tag);
            end else begin
                e = expq[0];
                check("tag", 64'(o_tag), 64'(e.tag));
                check("hash", 64'(hash_key), 64'(e.hash));
                check("err", 64'(o_err), 64'(e.err));
                if (!stall) begin
                    check("latency", 64'(ucount), 64'(e.acc + 14));
                    last_hash = hash_key;
                    void'(expq.pop_front());
                end
            end
        end
        if (start && !stall) begin
            e.tag  = v.tag;
            e.hash = v.hash;
            e.err  = v.err;
            e.acc  = ucount;
            expq.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || !o_empty) && n < 100) begin
            cycle(1'b0, idle, 1'b0);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding expected 0", expq.size());
            expq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] pat;
        logic [DW-1:0] ff_41;
        logic [DW-1:0] ff_00;
        logic [DW-1:0] ff_4142;
        vec_t          v;
        int            n;

        for (int i = 0; i < DB; i++) pat[DW-1-8*i -: 8] = 8'(i * 37 + 5);
        ff_41 = {DW{1'b1}};
        ff_41[DW-1 -: 8] = 8'h41;
        ff_00 = {DW{1'b1}};
        ff_00[DW-1 -: 8] = 8'h00;
        ff_4142 = {DW{1'b1}};
        ff_4142[DW-1 -: 16] = 16'h4142;

        tbl[0]  = '{pat,     32'd0,          8'h11, 16'h1505, 1'b0};
        tbl[1]  = '{ff_41,   32'd1,          8'h21, 16'hB5E4, 1'b0};
        tbl[2]  = '{ff_00,   32'd1,          8'h22, 16'hB5A5, 1'b0};
        tbl[3]  = '{ff_4142, 32'd2,          8'h23, 16'h7226, 1'b0};
        tbl[4]  = '{pat,     32'd52,         8'h30, ref_hash(pat, 32'd52), 1'b0};
        tbl[5]  = '{pat,     32'd60,         8'h31, ref_hash(pat, 32'd52), 1'b1};
        tbl[6]  = '{pat,     32'hFFFF_FF00,  8'h32, ref_hash(pat, 32'd52), 1'b1};
        tbl[7]  = '{pat,     32'h0000_0100,  8'h33, ref_hash(pat, 32'd52), 1'b1};
        tbl[8]  = '{pat,     32'd51,         8'h34, ref_hash(pat, 32'd51), 1'b0};
        tbl[9]  = '{pat,     32'd53,         8'h35, ref_hash(pat, 32'd52), 1'b1};
        tbl[10] = '{pat,     32'd4,          8'h36, ref_hash(pat, 32'd4),  1'b0};
        tbl[11] = '{pat,     32'd5,          8'h37, ref_hash(pat, 32'd5),  1'b0};
        idle = '{'0, 32'd0, 8'h00, 16'h0000, 1'b0};

        rstn = 1'b0;
        i_start = 1'b0;
        i_data = '0;
        i_length = '0;
        i_tag = '0;
        i_stall_pipe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_hash", 64'(hash_key), 64'd0);
        check("reset_tag", 64'(o_tag), 64'd0);
        check("reset_err", 64'(o_err), 64'd0);
        check("reset_empty", 64'(o_empty), 64'd1);

        // First request rides the first rising edge after release.
        cycle(1'b1, tbl[0], 1'b0);
        rstn = 1'b1;
        drain();

        // Isolated requests, one at a time.
        for (int i = 1; i < 12; i++) begin
            cycle(1'b1, tbl[i], 1'b0);
            drain();
        end
        check("idle_hold_hash", 64'(hash_key), 64'(tbl[11].hash));
        check("idle_hold_valid", 64'(o_valid), 64'd0);

        // Back-to-back stream of every vector.
        for (int i = 0; i < 12; i++) cycle(1'b1, tbl[i], 1'b0);
        check("busy_empty", 64'(o_empty), 64'd0);
        drain();

        // Three requests, stall mid-flight with a dropped start, then stall on a live result.
        for (int i = 1; i <= 3; i++) begin
            v = tbl[3 + i];
            v.tag = 8'(i);
            cycle(1'b1, v, 1'b0);
        end
        repeat (4) cycle(1'b0, idle, 1'b0);
        v = tbl[4];
        v.tag = 8'h44;
        for (int i = 0; i < 5; i++) cycle(i == 1, v, 1'b1);
        n = 0;
        while (!o_valid && n < 40) begin
            cycle(1'b0, idle, 1'b0);
            n++;
        end
        repeat (3) cycle(1'b0, idle, 1'b1);
        drain();
        check("stall_last_hash", 64'(last_hash), 64'(tbl[6].hash));

        // Reset with requests in flight and a result on the outputs.
        for (int i = 0; i < 4; i++) cycle(1'b1, tbl[8 + i], 1'b0);
        repeat (11) cycle(1'b0, idle, 1'b0);
        check("pre_reset_valid", 64'(o_valid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_valid", 64'(o_valid), 64'd0);
        check("async_empty", 64'(o_empty), 64'd1);
        check("async_hash", 64'(hash_key), 64'd0);
        check("async_tag", 64'(o_tag), 64'd0);
        expq.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) cycle(1'b0, idle, 1'b0);
        check("post_reset_empty", 64'(o_empty), 64'd1);

        // Pipeline still works after the flush.
        cycle(1'b1, tbl[3], 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hash_func_pipe_param.md
HASH_FUNC_PIPE_PARAM -- requirements
Module: hash_func_pipe_param

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 52, meaning the input key field width in bytes (416 bits).
REQ-002 SHALL have parameter BYTES_PER_STAGE, default 4, meaning the bytes folded per pipeline stage; DATA_BYTES SHALL be a multiple of it; NUM_STAGES = DATA_BYTES/BYTES_PER_STAGE (default 13).
REQ-003 SHALL have parameter KEY_W, default 16, meaning the hash output width (8..32).
REQ-004 SHALL have parameter SEED, default 16'h1505, meaning the initial hash value, truncated to KEY_W.
REQ-005 SHALL have parameter TAG_W, default 8, meaning the width of the sideband tag carried with each request.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rstn  input  1  reset, asynchronous, active-low.
REQ-008 i_data  input  8*DATA_BYTES  key bytes; byte 0 = i_data[8*DATA_BYTES-1 -: 8], byte k follows MSB-first.
REQ-009 i_length  input  32  number of valid key bytes.
REQ-010 i_tag  input  TAG_W  sideband ID, returned unchanged with the result.
REQ-011 i_start  input  1  request strobe.
REQ-012 i_stall_pipe  input  1  freezes the whole pipeline.
REQ-013 hash_key  output  KEY_W  hash result.
REQ-014 o_tag  output  TAG_W  tag of the current result.
REQ-015 o_err  output  1  request had i_length > DATA_BYTES.
REQ-016 o_valid  output  1  hash_key/o_tag/o_err are valid.
REQ-017 o_empty  output  1  no request in flight in any stage.

Function
REQ-018 SHALL compute h = SEED; for each byte b with index < min(i_length, DATA_BYTES), in index order: h = ((h*33) mod 2^KEY_W) XOR b.
REQ-019 SHALL leave h unchanged for bytes with index >= effective length, whatever their value.
REQ-020 SHALL produce hash_key = SEED for i_length = 0.
REQ-021 SHALL accept a request on a rising edge where i_start=1 and i_stall_pipe=0; i_start during a stall SHALL be ignored and the request lost.
REQ-022 SHALL process bytes [s*BYTES_PER_STAGE, (s+1)*BYTES_PER_STAGE) in stage s, s = 0..NUM_STAGES-1, each stage being a register holding valid, partial h, data, clamped length, tag and err.
REQ-023 SHALL present the result with o_valid=1 exactly NUM_STAGES unstalled edges after acceptance (default 13).
REQ-024 SHALL sustain one request per cycle; back-to-back results SHALL emerge in acceptance order with no loss or duplication.
REQ-025 While i_stall_pipe=1, all stage registers and all outputs SHALL hold their values.
REQ-026 Downstream SHALL consume a result only on an edge with o_valid=1 and i_stall_pipe=0; o_valid held during a stall is the same result.
REQ-027 SHALL set o_err=1 and hash the first DATA_BYTES bytes when i_length > DATA_BYTES, including values with bits 31..8 set.
REQ-028 SHALL drive o_valid=0 on cycles with no completing request; hash_key/o_tag/o_err then hold their last values.
REQ-029 SHALL drive o_empty=1 exactly when every stage valid bit and o_valid are 0.
REQ-030 SHALL perform all arithmetic at KEY_W bits, discarding carries beyond bit KEY_W-1.

Reset
REQ-031 On rstn=0, all stage valid bits SHALL clear immediately, without waiting for a clock edge.
REQ-032 On rstn=0, outputs SHALL go to o_valid=0, hash_key=0, o_tag=0, o_err=0, o_empty=1.
REQ-033 Requests in flight when reset asserts SHALL be discarded, and none SHALL appear after rstn returns high.
REQ-034 The first request SHALL be accepted on the first rising edge with rstn=1.

Verification
REQ-035 i_length=0, i_tag=8'h11 -> after 13 cycles: o_valid=1, hash_key=16'h1505, o_tag=8'h11, o_err=0.
REQ-036 i_length=1, byte0=8'h41, remaining bytes 8'hFF -> hash_key=16'hB5E4; repeat with byte0=8'h00 -> 16'hB5A5.
REQ-037 i_length=60 with the same 52 bytes as an i_length=52 request -> identical hash_key, o_err=1 versus 0.
REQ-038 Three back-to-back starts with tags 1,2,3, then i_stall_pipe=1 for 5 cycles mid-flight -> tags 1,2,3 in order, each consumed once, latency 13+5; i_start during the stall is dropped.
REQ-039 rstn pulsed low with 4 requests in flight -> o_valid=0 and o_empty=1 immediately; no o_valid for 20 cycles after release without new starts.
REQ-040 Random regression (KEY_W=16 and 32, BYTES_PER_STAGE=1/4/13) against a reference model of REQ-018 -> all hashes, tags and err flags match.
